// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl shared definitions: one-hot phase encoding, opcode field and
// opcode values, rd field position.
package seq_ctrl_pkg;

  typedef enum logic [3:0] {
    PH0 = 4'b0001,
    PH1 = 4'b0010,
    PH2 = 4'b0100,
    PH3 = 4'b1000
  } ph_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LI  = 4'h2;
  localparam logic [3:0] OP_B   = 4'h3;
  localparam logic [3:0] OP_BNZ = 4'h4;
  localparam logic [3:0] OP_SGT = 4'h5;
  localparam logic [3:0] OP_MLT = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// seq_decode: combinational instruction classifier shared by the sequencer
// and the register file. Unlisted opcodes decode to NOP (all flags low).
module seq_decode
  import seq_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_wr,
  output logic        is_br,
  output logic        is_hlt
);

  // Only the opcode field matters for classification.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[OPC_LSB-1:0];

  // Map opcode to its class.
  always_comb begin
    is_wr  = 1'b0;
    is_br  = 1'b0;
    is_hlt = 1'b0;
    case (opcode_of(ir))
      OP_ADD, OP_LI, OP_SGT, OP_MLT: is_wr  = 1'b1;
      OP_B, OP_BNZ:                  is_br  = 1'b1;
      OP_HLT:                        is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: four-phase instruction sequencer feeding the ALU.
// Optional build macro SEQ_SINGLE_STEP_EN adds a `step` input; each
// instruction then waits in an idle PH0 until a step pulse starts its fetch.
//
// state | meaning
// PH0   | fetch: request imem at pc until ack (idle when imem_req is low)
// PH1   | decode / register read
// PH2   | execute; write-class instructions arm rf_we for PH3
// PH3   | writeback: branch loads pc from q; HLT parks here forever
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          RF_AW    = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  input  logic [15:0]      q,
  output logic [15:0]      ir,
  output logic [15:0]      pc,
  output logic [3:0]       ph,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_wa,
  output logic             halted
);

  ph_e              ph_q, ph_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             req_q, req_d;
  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_wa_q, rf_wa_d;
  logic             halted_q, halted_d;

  logic is_wr, is_br, is_hlt;
  logic idle_go;
  logic wb_refetch;

`ifdef SEQ_SINGLE_STEP_EN
  assign idle_go    = step;
  assign wb_refetch = 1'b0;
`else
  assign idle_go    = 1'b1;
  assign wb_refetch = 1'b1;
`endif

  seq_decode u_decode (
    .ir     (ir_q),
    .is_wr  (is_wr),
    .is_br  (is_br),
    .is_hlt (is_hlt)
  );

  // Next-state computation for the phase machine and its registered outputs.
  always_comb begin
    ph_d     = ph_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    req_d    = req_q;
    rf_we_d  = rf_we_q;
    rf_wa_d  = rf_wa_q;
    halted_d = halted_q;
    case (ph_q)
      PH0: begin
        if (!req_q) begin
          req_d = idle_go;
        end else if (imem_ack) begin
          ir_d  = imem_rdata;
          pc_d  = pc_q + 16'd1;
          req_d = 1'b0;
          ph_d  = PH1;
        end
      end
      PH1: ph_d = PH2;
      PH2: begin
        ph_d = PH3;
        if (is_wr) begin
          rf_we_d = 1'b1;
          rf_wa_d = ir_q[RD_LSB +: RF_AW];
        end
      end
      PH3: begin
        rf_we_d = 1'b0;
        if (is_hlt) begin
          halted_d = 1'b1;
        end else begin
          if (is_br) pc_d = q;
          ph_d  = PH0;
          req_d = wb_refetch;
        end
      end
      default: ph_d = PH0;
    endcase
  end

  // Phase machine registers; reset drops any outstanding request at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ph_q     <= PH0;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      req_q    <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      halted_q <= halted_d;
    end
  end

  assign ph        = ph_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed steps plus a randomized instruction stream,
// checked against an instruction-level model of pc/ir/phase behaviour.
module tb_seq_ctrl;

  logic        CLK;
  logic        RSTN;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] q;
  logic [15:0] ir;
  logic [15:0] pc;
  logic [3:0]  ph;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic        halted;

  seq_ctrl #(.RESET_PC(16'h0000), .RF_AW(3)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .q          (q),
    .ir         (ir),
    .pc         (pc),
    .ph         (ph),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .halted     (halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: address of the next fetch and the held instruction.
  logic [15:0] m_pc;
  logic [15:0] m_ir;

`ifdef SEQ_SINGLE_STEP_EN
  localparam logic REFETCH = 1'b0;
`else
  localparam logic REFETCH = 1'b1;
`endif

  // Instruction class from the opcode table: 0 nop, 1 write, 2 branch, 3 halt.
  function automatic int cls(input logic [15:0] ins);
    case (ins[15:12])
      4'h1, 4'h2, 4'h5, 4'h6: return 1;
      4'h3, 4'h4:             return 2;
      4'hF:                   return 3;
      default:                return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One instruction from fetch request through writeback, with `waits`
  // non-acked requesting cycles and ALU result qv presented in PH3.
  task automatic run_instr(input logic [15:0] ins, input int waits, input logic [15:0] qv);
    int k;
    int c;
    c = cls(ins);
`ifdef SEQ_SINGLE_STEP_EN
    if (!imem_req) begin
      repeat (3) begin
        tick();
        chk("step_idle_req", imem_req, 1'b0);
        chk("step_idle_ph", ph, 4'b0001);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
    end
`endif
    k = 0;
    while (!imem_req && k < 8) begin
      tick();
      k++;
    end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_ph", ph, 4'b0001);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_ir_hold", ir, m_ir);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      tick();
      chk("wait_ph", ph, 4'b0001);
      chk("wait_ir", ir, m_ir);
      chk("wait_req", imem_req, 1'b1);
    end
    imem_ack = 1'b1;
    imem_rdata = ins;
    tick();
    m_ir = ins;
    m_pc = m_pc + 16'd1;
    chk("ph1_ph", ph, 4'b0010);
    chk("ph1_ir", ir, m_ir);
    chk("ph1_pc", pc, m_pc);
    chk("ph1_req", imem_req, 1'b0);
    imem_ack = 1'($urandom);
    imem_rdata = 16'($urandom);
    q = 16'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'($urandom);
`endif
    tick();
    chk("ph2_ph", ph, 4'b0100);
    chk("ph2_ir", ir, m_ir);
    chk("ph2_we", rf_we, 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    q = qv;
    imem_ack = 1'b1;
    imem_rdata = 16'($urandom);
    tick();
    chk("ph3_ph", ph, 4'b1000);
    chk("ph3_we", rf_we, (c == 1));
    if (c == 1) chk("ph3_wa", rf_wa, ins[10:8]);
    chk("ph3_pc", pc, m_pc);
    chk("ph3_ir", ir, m_ir);
    imem_ack = 1'($urandom);
    if (c == 3) begin
      tick();
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_ph", ph, 4'b1000);
      chk("hlt_we", rf_we, 1'b0);
      for (int i = 0; i < 20; i++) begin
        imem_ack = 1'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'($urandom);
`endif
        tick();
        chk("hlt_req", imem_req, 1'b0);
        chk("hlt_hold_ph", ph, 4'b1000);
      end
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b0;
`endif
    end else begin
      if (c == 2) m_pc = qv;
      tick();
      chk("wb_ph", ph, 4'b0001);
      chk("wb_pc", pc, m_pc);
      chk("wb_we", rf_we, 1'b0);
      chk("wb_halted", halted, 1'b0);
      chk("wb_req", imem_req, REFETCH);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] ins;
    logic [15:0] qv;
    RSTN = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    q = 16'h0000;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    m_pc = 16'h0000;
    m_ir = 16'h0000;
    tick();
    tick();
    chk("rst_ph", ph, 4'b0001);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_wa", rf_wa, 3'd0);
    chk("rst_halted", halted, 1'b0);

    // Release with ack tied high: ack before the first request is ignored.
    RSTN = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'h1512;
    run_instr(16'h1512, 0, 16'h1234);
    run_instr(16'h2300, 3, 16'h5A5A);
    run_instr(16'h3000, 0, 16'h0010);
    run_instr(16'h3000, 1, 16'h0008);
    run_instr(16'h4000, 0, m_pc + 16'd1);
    run_instr(16'h3000, 0, 16'hFFFF);
    run_instr(16'h0000, 2, 16'hBEEF);
    chk("wrap_pc", pc, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      if (ins[15:12] == 4'h4 && $urandom_range(0, 1) == 1) qv = m_pc + 16'd1;
      else qv = 16'($urandom);
      run_instr(ins, $urandom_range(0, 3), qv);
    end

    // Reset asserted in the middle of a pending fetch.
    imem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    tick();
    chk("midrst_pre_req", imem_req, 1'b1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_ph", ph, 4'b0001);
    chk("midrst_ir", ir, 16'h0000);
    #3;
    RSTN = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'h6700;
    m_pc = 16'h0000;
    m_ir = 16'h0000;
    run_instr(16'h6700, 1, 16'h0042);
    run_instr(16'hF000, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
